// File: rtl/jam_cost_responder.sv
// jam_cost_responder: cost-table responder and result checker for the JAM
// job-assignment engine. Holds the 8x8 cost table, answers W/J lookups
// combinationally, sequences JAM through reset/run and grades its result
// against golden values.
// Optional build macro: JAM_ACCESS_CNT_EN adds the access_count output.
module jam_cost_responder #(
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned MAX_CYCLES = 10000000,
    parameter int unsigned ARM_CYCLES = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [6:0]       ld_data,
    input  logic [8:0]       gold_min_cost,
    input  logic [3:0]       gold_match_count,
    input  logic             clear,
    input  logic [2:0]       W,
    input  logic [2:0]       J,
    output logic [6:0]       Cost,
    output logic             jam_rst,
    input  logic             Valid,
    input  logic [8:0]       MinCost,
    input  logic [3:0]       MatchCount,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [8:0]       got_min_cost,
    output logic [3:0]       got_match_count
`ifdef JAM_ACCESS_CNT_EN
    ,
    output logic [15:0]      access_count
`endif
);

    localparam int unsigned      ARM_W    = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       wr_ptr_q, wr_ptr_d;
    logic [6:0]       mem_q [64];
    logic [6:0]       mem_d [64];
    logic [8:0]       gold_min_q, gold_min_d;
    logic [3:0]       gold_cnt_q, gold_cnt_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [8:0]       got_min_q, got_min_d;
    logic [3:0]       got_cnt_q, got_cnt_d;

    // State register and all datapath flops; RST overrides everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            for (int unsigned i = 0; i < 64; i++) mem_q[i] <= '0;
            gold_min_q <= '0;
            gold_cnt_q <= '0;
            arm_cnt_q  <= '0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cycle_q    <= '0;
            got_min_q  <= '0;
            got_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            for (int unsigned i = 0; i < 64; i++) mem_q[i] <= mem_d[i];
            gold_min_q <= gold_min_d;
            gold_cnt_q <= gold_cnt_d;
            arm_cnt_q  <= arm_cnt_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            cycle_q    <= cycle_d;
            got_min_q  <= got_min_d;
            got_cnt_q  <= got_cnt_d;
        end
    end

    // Next-state: table load, arm delay, run/grade, and clear back to idle.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        mem_d      = mem_q;
        gold_min_d = gold_min_q;
        gold_cnt_d = gold_cnt_q;
        arm_cnt_d  = arm_cnt_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        cycle_d    = cycle_q;
        got_min_d  = got_min_q;
        got_cnt_d  = got_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ld_valid) begin
                    mem_d[wr_ptr_q] = ld_data;
                    wr_ptr_d        = wr_ptr_q + 6'd1;
                    if (wr_ptr_q == 6'd63) begin
                        gold_min_d = gold_min_cost;
                        gold_cnt_d = gold_match_count;
                        arm_cnt_d  = '0;
                        state_d    = S_ARM;
                    end
                end
            end
            S_ARM: begin
                cycle_d = '0;
                if (arm_cnt_q == ARM_LAST) state_d = S_RUN;
                else arm_cnt_d = arm_cnt_q + 1'b1;
            end
            S_RUN: begin
                // Valid takes priority over an expiring budget.
                if (Valid) begin
                    got_min_d = MinCost;
                    got_cnt_d = MatchCount;
                    pass_d    = (MinCost == gold_min_q) && (MatchCount == gold_cnt_q);
                    state_d   = S_DONE;
                end else if (cycle_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = S_TIMEOUT;
                end else begin
                    cycle_d = cycle_q + 1'b1;
                end
            end
            S_DONE, S_TIMEOUT: begin
                if (clear) begin
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    cycle_d   = '0;
                    got_min_d = '0;
                    got_cnt_d = '0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Combinational lookup and state-decoded status outputs.
    always_comb begin
        Cost            = mem_q[{W, J}];
        ld_ready        = (state_q == S_IDLE);
        busy            = (state_q == S_ARM) || (state_q == S_RUN);
        done            = (state_q == S_DONE) || (state_q == S_TIMEOUT);
        jam_rst         = (state_q != S_RUN);
        pass            = pass_q;
        timeout         = timeout_q;
        cycle_count     = cycle_q;
        got_min_cost    = got_min_q;
        got_match_count = got_cnt_q;
    end

`ifdef JAM_ACCESS_CNT_EN
    logic [15:0] acc_q, acc_d;
    logic [5:0]  prev_wj_q, prev_wj_d;

    // Access-count registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q     <= '0;
            prev_wj_q <= '0;
        end else begin
            acc_q     <= acc_d;
            prev_wj_q <= prev_wj_d;
        end
    end

    // Count RUN cycles whose {W,J} differs from the previous cycle's.
    always_comb begin
        acc_d     = acc_q;
        prev_wj_d = prev_wj_q;
        if (state_q == S_IDLE && state_d == S_ARM) acc_d = '0;
        if (state_q == S_ARM && state_d == S_RUN) prev_wj_d = {W, J};
        if (state_q == S_RUN) begin
            prev_wj_d = {W, J};
            if (({W, J} != prev_wj_q) && (acc_q != 16'hFFFF)) acc_d = acc_q + 16'd1;
        end
        access_count = acc_q;
    end
`endif

endmodule
